// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and BCD helpers for the 12-hour wall-clock set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [7:0] HOUR_RESET = 8'h12;
  localparam logic [7:0] HOUR_MAX   = 8'h12;
  localparam logic [7:0] HOUR_MIN   = 8'h01;
  localparam logic [7:0] HOUR_PM_SW = 8'h11;  // stepping off 11 flips AM/PM
  localparam logic [7:0] MIN_MAX    = 8'h59;
  localparam logic [7:0] MIN_MIN    = 8'h00;
  localparam logic [7:0] SEC_LOAD   = 8'h00;

  // Next 2-digit BCD value, wrapping from max_val back to min_val.
  function automatic logic [7:0] bcd_inc_mod(input logic [7:0] value,
                                             input logic [7:0] max_val,
                                             input logic [7:0] min_val);
    logic [7:0] next_v;
    if (value == max_val) begin
      next_v = min_val;
    end else if (value[3:0] >= 4'd9) begin
      next_v = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_v = {value[7:4], value[3:0] + 4'd1};
    end
    return next_v;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / counter-side signal bundle of the clock set controller.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic       pm_in;
  logic       cnt_ena;
  logic       ld_valid;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;
  logic       ld_pm;
  logic [1:0] mode;

  // Environment side: buttons and live counter value in, controls out.
  modport master (
    output btn_mode, btn_inc, hh_in, mm_in, pm_in,
    input  cnt_ena, ld_valid, ld_hh, ld_mm, ld_ss, ld_pm, mode
  );

  // Controller side.
  modport slave (
    input  btn_mode, btn_inc, hh_in, mm_in, pm_in,
    output cnt_ena, ld_valid, ld_hh, ld_mm, ld_ss, ld_pm, mode
  );
endinterface

// File: rtl/clock_set_ctrl_tick.sv
// Prescaler producing a one-cycle enable every TICK_DIV cycles.
// clear and hold both force the count to zero and suppress the pulse.
module clock_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic cnt_ena
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r;
  logic          cnt_ena_r;

  // Count 0..TICK_DIV-1; pulse in the cycle after the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear || hold) begin
      presc_r   <= '0;
      cnt_ena_r <= 1'b0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r   <= '0;
      cnt_ena_r <= 1'b1;
    end else begin
      presc_r   <= presc_r + PW'(1);
      cnt_ena_r <= 1'b0;
    end
  end

  assign cnt_ena = cnt_ena_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the 12-hour BCD counter: seconds enable,
// hours/minutes edit FSM with shadow registers, and one-cycle load strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);

  mode_e      mode_r;
  logic       ld_valid_r;
  logic [7:0] hh_r;
  logic [7:0] mm_r;
  logic       pm_r;
  logic       enter_edit_s;
  logic       hold_s;
  logic       cnt_ena_s;

  // Clearing on the entry edge keeps cnt_ena low in the first edit cycle.
  assign enter_edit_s = (mode_r == MODE_RUN) && bus.btn_mode;
  assign hold_s       = (mode_r != MODE_RUN);

  clock_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (enter_edit_s),
    .hold    (hold_s),
    .cnt_ena (cnt_ena_s)
  );

  // Edit FSM and shadow time registers; mode advance beats increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r     <= MODE_RUN;
      ld_valid_r <= 1'b0;
      hh_r       <= HOUR_RESET;
      mm_r       <= MIN_MIN;
      pm_r       <= 1'b0;
    end else begin
      ld_valid_r <= 1'b0;
      case (mode_r)
        MODE_RUN: begin
          if (bus.btn_mode) begin
            mode_r <= MODE_SET_HR;
            hh_r   <= bus.hh_in;
            mm_r   <= bus.mm_in;
            pm_r   <= bus.pm_in;
          end else begin
            mode_r <= MODE_RUN;
          end
        end
        MODE_SET_HR: begin
          if (bus.btn_mode) begin
            mode_r <= MODE_SET_MIN;
          end else if (bus.btn_inc) begin
            hh_r <= bcd_inc_mod(hh_r, HOUR_MAX, HOUR_MIN);
            if (hh_r == HOUR_PM_SW) begin
              pm_r <= ~pm_r;
            end else begin
              pm_r <= pm_r;
            end
          end else begin
            mode_r <= MODE_SET_HR;
          end
        end
        MODE_SET_MIN: begin
          if (bus.btn_mode) begin
            mode_r     <= MODE_RUN;
            ld_valid_r <= 1'b1;
          end else if (bus.btn_inc) begin
            mm_r <= bcd_inc_mod(mm_r, MIN_MAX, MIN_MIN);
          end else begin
            mode_r <= MODE_SET_MIN;
          end
        end
        default: begin
          mode_r <= MODE_RUN;
        end
      endcase
    end
  end

  assign bus.cnt_ena  = cnt_ena_s;
  assign bus.ld_valid = ld_valid_r;
  assign bus.ld_hh    = hh_r;
  assign bus.ld_mm    = mm_r;
  assign bus.ld_ss    = SEC_LOAD;
  assign bus.ld_pm    = pm_r;
  assign bus.mode     = mode_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench: two controllers (TICK_DIV=4 and TICK_DIV=1) share the
// same stimulus; a time-arithmetic model predicts every registered output.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hh_in = 8'h12;
  logic [7:0] mm_in = 8'h00;
  logic       pm_in = 1'b0;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl_if if4 ();
  clock_set_ctrl_if if1 ();

  assign if4.btn_mode = btn_mode;
  assign if4.btn_inc  = btn_inc;
  assign if4.hh_in    = hh_in;
  assign if4.mm_in    = mm_in;
  assign if4.pm_in    = pm_in;
  assign if1.btn_mode = btn_mode;
  assign if1.btn_inc  = btn_inc;
  assign if1.hh_in    = hh_in;
  assign if1.mm_in    = mm_in;
  assign if1.pm_in    = pm_in;

  clock_set_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  clock_set_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    bit ena4;
    bit ena1;
    bit lv;
    int hh;
    int mm;
    bit pm;
  } exp_t;

  typedef struct {
    int hh;
    int mm;
    bit pm;
  } commit_t;

  exp_t    exp_q[$];
  commit_t cq4[$];
  commit_t cq1[$];

  // Reference model state: time held as plain integers.
  int m_mode = 0;
  int m_hh = 12;
  int m_mm = 0;
  bit m_pm = 1'b0;
  int m_run_cycles = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of stimulus and push the model's prediction for the edge.
  task automatic cyc(input bit bm, input bit bi, input bit rs,
                     input int hh, input int mm, input bit pm);
    exp_t e;
    commit_t c;
    @(negedge clk);
    btn_mode = bm;
    btn_inc  = bi;
    reset    = rs;
    hh_in    = to_bcd(hh);
    mm_in    = to_bcd(mm);
    pm_in    = pm;
    e.ena4 = 1'b0;
    e.ena1 = 1'b0;
    e.lv   = 1'b0;
    if (rs) begin
      m_mode = 0; m_hh = 12; m_mm = 0; m_pm = 1'b0; m_run_cycles = 0;
    end else if (m_mode == 0) begin
      if (bm) begin
        m_mode = 1; m_hh = hh; m_mm = mm; m_pm = pm;
      end else begin
        m_run_cycles++;
        e.ena4 = (m_run_cycles % 4) == 0;
        e.ena1 = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (bm) begin
        m_mode = 2;
      end else if (bi) begin
        if (m_hh == 11) m_pm = ~m_pm;
        m_hh = (m_hh == 12) ? 1 : m_hh + 1;
      end
    end else begin
      if (bm) begin
        m_mode = 0; m_run_cycles = 0; e.lv = 1'b1;
        c.hh = m_hh; c.mm = m_mm; c.pm = m_pm;
        cq4.push_back(c);
        cq1.push_back(c);
      end else if (bi) begin
        m_mm = (m_mm + 1) % 60;
      end
    end
    e.mode = m_mode; e.hh = m_hh; e.mm = m_mm; e.pm = m_pm;
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge pop the prediction and compare both DUTs.
  always @(posedge clk) begin
    exp_t e;
    commit_t c;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mode4", 32'(if4.mode), 32'(e.mode));
      chk("mode1", 32'(if1.mode), 32'(e.mode));
      chk("cnt_ena4", 32'(if4.cnt_ena), 32'(e.ena4));
      chk("cnt_ena1", 32'(if1.cnt_ena), 32'(e.ena1));
      chk("ld_valid4", 32'(if4.ld_valid), 32'(e.lv));
      chk("ld_valid1", 32'(if1.ld_valid), 32'(e.lv));
      chk("ld_hh4", 32'(if4.ld_hh), 32'(to_bcd(e.hh)));
      chk("ld_hh1", 32'(if1.ld_hh), 32'(to_bcd(e.hh)));
      chk("ld_mm4", 32'(if4.ld_mm), 32'(to_bcd(e.mm)));
      chk("ld_mm1", 32'(if1.ld_mm), 32'(to_bcd(e.mm)));
      chk("ld_pm4", 32'(if4.ld_pm), 32'(e.pm));
      chk("ld_pm1", 32'(if1.ld_pm), 32'(e.pm));
      chk("ld_ss4", 32'(if4.ld_ss), 32'h0);
      if (if4.ld_valid === 1'b1) begin
        if (cq4.size() == 0) begin
          chk("commit4_unexpected", 32'(1), 32'(0));
        end else begin
          c = cq4.pop_front();
          chk("commit4_hh", 32'(from_bcd(if4.ld_hh)), 32'(c.hh));
          chk("commit4_mm", 32'(from_bcd(if4.ld_mm)), 32'(c.mm));
          chk("commit4_pm", 32'(if4.ld_pm), 32'(c.pm));
        end
      end
      if (if1.ld_valid === 1'b1) begin
        if (cq1.size() == 0) begin
          chk("commit1_unexpected", 32'(1), 32'(0));
        end else begin
          c = cq1.pop_front();
          chk("commit1_hh", 32'(from_bcd(if1.ld_hh)), 32'(c.hh));
          chk("commit1_mm", 32'(from_bcd(if1.ld_mm)), 32'(c.mm));
          chk("commit1_pm", 32'(if1.ld_pm), 32'(c.pm));
        end
      end
    end
  end

  // Directed scenarios, then randomized button/reset traffic.
  initial begin
    cyc(0, 0, 1, 12, 0, 0);
    cyc(0, 0, 1, 12, 0, 0);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 12, 0, 0);
    // Edit from 11:58 AM: hours 12 (pm flips), 01; minutes 59, 00, 01; commit.
    cyc(1, 0, 0, 11, 58, 0);
    cyc(0, 1, 0, 3, 7, 1);
    cyc(0, 1, 0, 3, 7, 1);
    cyc(1, 0, 0, 3, 7, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3, 7, 1);
    cyc(1, 0, 0, 3, 7, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 3, 7, 1);
    // Mode and inc together in SET_HR, then 09->10 step, then reset mid-edit.
    cyc(1, 0, 0, 9, 9, 1);
    cyc(0, 1, 0, 9, 9, 1);
    cyc(1, 1, 0, 9, 9, 1);
    cyc(0, 1, 0, 9, 9, 1);
    cyc(0, 0, 1, 9, 9, 1);
    // Increments in RUN are ignored.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 5, 5, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 299) == 0), int'($urandom_range(1, 12)),
          int'($urandom_range(0, 59)), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 12, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    chk("commit4_drained", 32'(cq4.size()), 32'(0));
    chk("commit1_drained", 32'(cq1.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Controller that sequences and configures the 12-hour BCD wall-clock counter (hh/mm/ss/pm).
- Generates the counter's once-per-second enable pulse from a prescaler.
- Runs a user time-set state machine: hours, then minutes, driven by two button pulses.
- Commits the edited time to the counter through a one-cycle load strobe, then resumes counting.

Parameters:
- TICK_DIV, 100, clk cycles per counter enable pulse; legal range ≥1; TICK_DIV=1 gives cnt_ena every RUN cycle.
- PW, $clog2(TICK_DIV+1), prescaler width (derived, not user-set).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  debounced one-cycle pulse: advance edit mode
- btn_inc  in  1  debounced one-cycle pulse: increment the field being edited
- hh_in  in  8  current counter hours, 2-digit BCD 01..12
- mm_in  in  8  current counter minutes, BCD 00..59
- pm_in  in  1  current counter PM flag
- cnt_ena  out  1  enable pulse to counter, registered
- ld_valid  out  1  one-cycle load strobe to counter, registered
- ld_hh  out  8  shadow hours, BCD; displayed while editing, loaded on strobe
- ld_mm  out  8  shadow minutes, BCD
- ld_ss  out  8  load seconds, constant 8'h00
- ld_pm  out  1  shadow PM flag
- mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN (3 unused)

Behaviour:
- Reset values (cycle after reset high): mode=RUN, prescaler=0, cnt_ena=0, ld_valid=0, ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00, ld_pm=0.
- Reset has priority over every input, including mid-edit. An edit aborted by reset never asserts ld_valid.
- Prescaler behaviour in RUN:
  - Counts 0..TICK_DIV-1 and wraps.
  - cnt_ena=1 in the cycle after the prescaler's value is TICK_DIV-1, else 0.
  - So the first pulse comes TICK_DIV cycles after reset release.
- In SET_HR and SET_MIN: prescaler held at 0 and cnt_ena=0. The counter is frozen.
- FSM transitions (btn_mode sampled at the clock edge):
  - RUN → SET_HR: shadow registers capture hh_in/mm_in/pm_in in the same edge.
  - SET_HR → SET_MIN.
  - SET_MIN → RUN: ld_valid=1 for exactly one cycle, driving the shadows with ld_ss=00. The prescaler restarts at 0, so the next cnt_ena arrives TICK_DIV cycles after the ld_valid cycle.
- btn_inc in SET_HR: hours step 12→01→02…→11→12 (BCD).
  - ld_pm toggles on the 11→12 step only.
  - 09→10 gives 8'h10, not 8'h0A.
- btn_inc in SET_MIN: minutes step 00..59 in BCD.
  - 59→00 wraps with no carry into hours or pm.
  - x9→(x+1)0 digit carry, e.g. 8'h09→8'h10.
- btn_inc in RUN: ignored.
- btn_mode and btn_inc in the same cycle: mode advance wins and the increment is dropped.
- Shadow outputs ld_hh/ld_mm/ld_pm stay at last values in RUN; they only change on capture or increment.
- Out-of-range hh_in/mm_in captured on entry are not corrected. The first increment uses BCD rules on the low/high nibbles as given; verification uses legal inputs only.
- All outputs are registers; no combinational input-to-output path.

Decomposition:
- Shared package (clock_pkg):
  - mode enum (RUN, SET_HR, SET_MIN)
  - BCD constants: hour reset 8'h12, hour max 8'h12, minute max 8'h59
  - function bcd_inc_mod(value, max, min) returning next BCD value
- Sub-module: clock_tick_gen (prescaler with clear and hold inputs, cnt_ena output). It is reusable for the seconds tick elsewhere.
- FSM and shadow registers stay in clock_set_ctrl.

Test Plan:
- Reset, TICK_DIV=4, no buttons → cnt_ena pulses at cycles 4,8,12 after release; mode=0, ld_valid never high.
- Enter edit with hh_in=8'h11, pm_in=0, mm_in=8'h58 (btn_mode). Then btn_inc ×2 → ld_hh 8'h12 then 8'h01, ld_pm=1 after the first step; cnt_ena stays 0 throughout.
- SET_MIN from 8'h58, btn_inc ×3 → 8'h59, 8'h00, 8'h01; ld_hh unchanged. Then btn_mode → ld_valid one cycle with hh=01, mm=01, ss=00, pm=1; first cnt_ena exactly TICK_DIV cycles later.
- btn_mode and btn_inc in the same cycle in SET_HR → mode=2, ld_hh unchanged.
- Reset asserted while mode=2 → next cycle mode=0, ld_hh=8'h12, ld_mm=00, ld_pm=0, no ld_valid.
- TICK_DIV=1: cnt_ena high every RUN cycle and low during edit; btn_inc in RUN leaves all ld_* unchanged.
